// File: rtl/fp_stim_gen.sv
// Multi-channel operand stimulus generator for FP multiplier benches.
// Emits ramp, LFSR, hold or IEEE-754 corner vectors with stall back-pressure and a run length.
module fp_stim_gen #(
    parameter int          WIDTH  = 32,
    parameter int          N_CH   = 2,
    parameter int          N_VECT = 256,
    parameter logic [31:0] SEED   = 32'hACE12BAD,
    parameter logic [31:0] TAPS   = 32'hA3000000,
    localparam int         CNT_W  = $clog2(N_VECT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    stall,
    output logic [N_CH*WIDTH-1:0]   data,
    output logic                    valid,
    output logic                    done,
    output logic [CNT_W-1:0]        count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] widen32(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH && i < 32; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECT - 1);
    localparam logic [WIDTH-1:0] CH_STEP  = WIDTH'(N_CH);
    localparam logic [WIDTH-1:0] TAP_MASK = widen32(TAPS);

    function automatic logic [WIDTH-1:0] seed_of(input int c);
        logic [31:0]      mix;
        logic [WIDTH-1:0] s;
        mix = SEED ^ (32'(c) * 32'h9E3779B9);
        s   = widen32(mix);
        // An all-zero Galois state never leaves zero.
        if (s == '0) begin
            s = WIDTH'(1);
        end
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ TAP_MASK;
        end
        return r;
    endfunction

    function automatic logic [31:0] corner_word(input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = 32'h0000_0000;
            3'd1:    w = 32'h8000_0000;
            3'd2:    w = 32'h3F80_0000;
            3'd3:    w = 32'hBF80_0000;
            3'd4:    w = 32'h7F80_0000;
            3'd5:    w = 32'h7FC0_0000;
            3'd6:    w = 32'h0000_0001;
            default: w = 32'h7F7F_FFFF;
        endcase
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] chan_value(
        input logic [1:0]       m,
        input int               c,
        input logic [WIDTH-1:0] base,
        input logic [2:0]       cidx,
        input logic [WIDTH-1:0] st
    );
        logic [WIDTH-1:0] v;
        case (m)
            2'd0:    v = base + WIDTH'(c);
            2'd1:    v = st;
            2'd2:    v = seed_of(c);
            default: begin
                // The corner table only makes sense for single precision.
                if (WIDTH == 32) begin
                    v = WIDTH'(corner_word(cidx + 3'(c)));
                end else begin
                    v = st;
                end
            end
        endcase
        return v;
    endfunction

    state_t                       state_q;
    state_t                       state_d;
    logic                         seed_en;
    logic                         first_en;
    logic                         acc_en;
    logic                         last_en;

    logic [1:0]                   mode_q;
    logic [N_CH-1:0][WIDTH-1:0]   lfsr_p0;
    logic [WIDTH-1:0]             base_p0;
    logic [2:0]                   cidx_p0;
    logic [N_CH-1:0][WIDTH-1:0]   vec_p0;

    logic [N_CH-1:0][WIDTH-1:0]   data_p1;
    logic                         vld_p1;
    logic                         done_q;
    logic [CNT_W-1:0]             count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LOAD is the one-cycle gap between seeding the generators and presenting vector 0.
    always_comb begin
        state_d  = state_q;
        seed_en  = 1'b0;
        first_en = 1'b0;
        acc_en   = 1'b0;
        last_en  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    seed_en = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                first_en = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (vld_p1 && !stall) begin
                    acc_en = 1'b1;
                    if (count_q == LAST_IDX) begin
                        last_en = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0: generator state always describes the next vector to be presented.
    always_comb begin
        vec_p0 = '0;
        for (int c = 0; c < N_CH; c++) begin
            vec_p0[c] = chan_value(mode_q, c, base_p0, cidx_p0, lfsr_p0[c]);
        end
    end

    // Stage p1: output register, advanced on first load and on every non-final accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            lfsr_p0 <= '0;
            base_p0 <= '0;
            cidx_p0 <= 3'd0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (seed_en) begin
                mode_q <= mode;
                for (int c = 0; c < N_CH; c++) begin
                    lfsr_p0[c] <= seed_of(c);
                end
                base_p0 <= '0;
                cidx_p0 <= 3'd0;
                count_q <= '0;
                done_q  <= 1'b0;
            end
            if (first_en || (acc_en && !last_en)) begin
                data_p1 <= vec_p0;
                for (int c = 0; c < N_CH; c++) begin
                    lfsr_p0[c] <= lfsr_step(lfsr_p0[c]);
                end
                base_p0 <= base_p0 + CH_STEP;
                cidx_p0 <= cidx_p0 + 3'd1;
                vld_p1  <= 1'b1;
            end
            if (acc_en) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (last_en) begin
                vld_p1 <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign data  = data_p1;
    assign valid = vld_p1;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_fp_stim_gen.sv
// Scoreboard bench for fp_stim_gen: directed runs push expected vectors,
// monitors pop and compare on every accepted vector.
module tb_fp_stim_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        stall;
    logic [63:0] data;
    logic        valid;
    logic        done;
    logic [8:0]  count;

    logic        start8;
    logic [1:0]  mode8;
    logic        stall8;
    logic [63:0] data8;
    logic        valid8;
    logic        done8;
    logic [3:0]  count8;

    int checks;
    int errors;

    logic [63:0] q [$];
    logic [63:0] q8 [$];
    logic [63:0] model_v [256];
    logic [63:0] e_a;
    logic [63:0] e_b;

    logic [31:0] ct [8];

    fp_stim_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .stall (stall),
        .data  (data),
        .valid (valid),
        .done  (done),
        .count (count)
    );

    fp_stim_gen #(.N_VECT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .mode  (mode8),
        .stall (stall8),
        .data  (data8),
        .valid (valid8),
        .done  (done8),
        .count (count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && valid && !stall) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL vector_extra: got %h expected none", data);
            end else begin
                e_a = q.pop_front();
                if (data !== e_a) begin
                    errors++;
                    $display("FAIL vector: got %h expected %h", data, e_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid8 && !stall8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL vector8_extra: got %h expected none", data8);
            end else begin
                e_b = q8.pop_front();
                if (data8 !== e_b) begin
                    errors++;
                    $display("FAIL vector8: got %h expected %h", data8, e_b);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_seed(input int c);
        logic [31:0] s;
        s = 32'hACE12BAD ^ (32'(c) * 32'h9E3779B9);
        if (s == 32'd0) s = 32'd1;
        return s;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    task automatic fill_model(input logic [1:0] m);
        logic [31:0] st [2];
        logic [31:0] v [2];
        st[0] = m_seed(0);
        st[1] = m_seed(1);
        q.delete();
        for (int n = 0; n < 256; n++) begin
            for (int c = 0; c < 2; c++) begin
                case (m)
                    2'd0:    v[c] = 32'(2 * n + c);
                    2'd1:    v[c] = st[c];
                    default: v[c] = m_seed(c);
                endcase
                st[c] = m_step(st[c]);
            end
            model_v[n] = {v[1], v[0]};
            q.push_back(model_v[n]);
        end
    endtask

    task automatic start_run(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        mode  = m ^ 2'b11;
        chk("start_valid", {63'd0, valid}, 64'd0);
        chk("start_count", {55'd0, count}, 64'd0);
        chk("start_done", {63'd0, done}, 64'd0);
        tick(1);
        chk("first_valid", {63'd0, valid}, 64'd1);
        chk("first_vector", data, model_v[0]);
    endtask

    task automatic run_main(input int stall_at, input int poke_at, output int vcnt);
        bit stalled;
        bit ok;
        stalled = 1'b0;
        ok      = 1'b0;
        vcnt    = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (valid) vcnt++;
            start = (cyc == poke_at);
            if (stall_at >= 0 && !stalled && valid && count == 9'(stall_at)) begin
                stalled = 1'b1;
                stall   = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    tick(1);
                    chk("stall_data", data, model_v[stall_at]);
                    chk("stall_valid", {63'd0, valid}, 64'd1);
                    chk("stall_count", {55'd0, count}, 64'(stall_at));
                end
                stall = 1'b0;
            end
            tick(1);
        end
        start = 1'b0;
        chk("run_timeout", {63'd0, ok}, 64'd1);
        chk("end_count", {55'd0, count}, 64'd256);
        chk("end_valid", {63'd0, valid}, 64'd0);
        chk("end_queue", 64'(q.size()), 64'd0);
    endtask

    task automatic run8();
        bit ok;
        ok = 1'b0;
        q8.delete();
        for (int n = 0; n < 8; n++) begin
            q8.push_back({ct[(n + 1) % 8], ct[n % 8]});
        end
        mode8  = 2'd3;
        start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
        mode8  = 2'd0;
        chk("c8_start_count", {60'd0, count8}, 64'd0);
        chk("c8_start_done", {63'd0, done8}, 64'd0);
        tick(1);
        chk("c8_first_valid", {63'd0, valid8}, 64'd1);
        chk("c8_first_vector", data8, 64'h8000_0000_0000_0000);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done8) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("c8_timeout", {63'd0, ok}, 64'd1);
        chk("c8_count", {60'd0, count8}, 64'd8);
        chk("c8_valid", {63'd0, valid8}, 64'd0);
        chk("c8_last_data", data8, 64'h0000_0000_7F7F_FFFF);
        chk("c8_queue", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        int  vcnt;
        bit  ok;
        ct[0] = 32'h0000_0000; ct[1] = 32'h8000_0000;
        ct[2] = 32'h3F80_0000; ct[3] = 32'hBF80_0000;
        ct[4] = 32'h7F80_0000; ct[5] = 32'h7FC0_0000;
        ct[6] = 32'h0000_0001; ct[7] = 32'h7F7F_FFFF;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        mode   = 2'd0;
        stall  = 1'b0;
        start8 = 1'b0;
        mode8  = 2'd0;
        stall8 = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_data", data, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_count", {55'd0, count}, 64'd0);

        // Ramp, no stall, with a START pulse mid-run that must be ignored.
        fill_model(2'd0);
        start_run(2'd0);
        run_main(-1, 50, vcnt);
        chk("ramp_valid_cycles", 64'(vcnt), 64'd256);
        chk("ramp_done", {63'd0, done}, 64'd1);
        chk("ramp_last_data", data, {32'd511, 32'd510});

        // LFSR restart from DONE with a 3-cycle stall at count 10.
        fill_model(2'd1);
        start_run(2'd1);
        chk("lfsr_v0_ch0", {32'd0, data[31:0]}, 64'h0000_0000_ACE1_2BAD);
        tick(1);
        chk("lfsr_v1_ch0", {32'd0, data[31:0]}, 64'h0000_0000_F570_95D6);
        chk("lfsr_v1_count", {55'd0, count}, 64'd1);
        run_main(10, -1, vcnt);
        chk("lfsr_done", {63'd0, done}, 64'd1);

        // Asynchronous reset mid-run at count 5.
        fill_model(2'd0);
        start_run(2'd0);
        ok = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (count == 9'd5) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("mid_reach5", {63'd0, ok}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data, 64'd0);
        chk("mid_rst_valid", {63'd0, valid}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_count", {55'd0, count}, 64'd0);
        q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_valid", {63'd0, valid}, 64'd0);

        // Hold mode from IDLE.
        fill_model(2'd2);
        start_run(2'd2);
        run_main(-1, -1, vcnt);

        // Corner table on the short-run instance, then restart from DONE.
        run8();
        run8();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
